// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction
// memory, and hands {pc, instr} pairs to decode in order over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] DEPTH_SUM = SW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_stale;
  logic [CW-1:0] r_out_cnt;

  logic [31:0]   r_pq_mem [DEPTH];
  logic [AW-1:0] r_pq_wr;
  logic [AW-1:0] r_pq_rd;

  logic [31:0]   r_oq_pc    [DEPTH];
  logic [31:0]   r_oq_instr [DEPTH];
  logic [AW-1:0] r_oq_wr;
  logic [AW-1:0] r_oq_rd;

  logic          w_pop;
  logic          w_accept;
  logic          w_rsp_drop;
  logic          w_rsp_keep;
  logic [SW-1:0] w_credit_used;
  logic [SW-1:0] w_inflight_sum;
  logic [CW-1:0] w_outst_next;
  logic [31:0]   w_redirect_target;
  logic          w_unused_bits;

  assign if_valid = (r_out_cnt != '0);
  assign if_instr = r_oq_instr[r_oq_rd];
  assign if_pc    = r_oq_pc[r_oq_rd];
  assign w_pop    = if_valid && if_ready;

  // A slot freed by this cycle's decode pop is reusable immediately; without
  // that, DEPTH=2 could not keep one instruction per cycle flowing.
  assign w_inflight_sum = {1'b0, r_outst} + {1'b0, r_out_cnt};
  assign w_credit_used  = w_inflight_sum - SW'(w_pop);

  assign imem_req_valid = rst_n && !redirect_valid && (w_credit_used < DEPTH_SUM);
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  assign w_rsp_drop   = (r_stale != '0) || redirect_valid;
  assign w_rsp_keep   = imem_rsp_valid && !w_rsp_drop;
  assign w_outst_next = r_outst + CW'(w_accept) - CW'(imem_rsp_valid);

  assign w_redirect_target = {redirect_pc[31:2], 2'b00};
  assign w_unused_bits     = ^redirect_pc[1:0];

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_outst   <= '0;
      r_stale   <= '0;
      r_out_cnt <= '0;
      r_pq_wr   <= '0;
      r_pq_rd   <= '0;
      r_oq_wr   <= '0;
      r_oq_rd   <= '0;
    end else begin
      r_outst <= w_outst_next;
      if (redirect_valid) begin
        r_pc      <= w_redirect_target;
        r_stale   <= w_outst_next;
        r_out_cnt <= '0;
        r_pq_wr   <= '0;
        r_pq_rd   <= '0;
        r_oq_wr   <= '0;
        r_oq_rd   <= '0;
      end else begin
        if (w_accept) begin
          r_pc    <= r_pc + 32'd4;
          r_pq_wr <= r_pq_wr + 1'b1;
        end
        if (imem_rsp_valid && (r_stale != '0)) begin
          r_stale <= r_stale - 1'b1;
        end
        if (w_rsp_keep) begin
          r_pq_rd <= r_pq_rd + 1'b1;
          r_oq_wr <= r_oq_wr + 1'b1;
        end
        if (w_pop) begin
          r_oq_rd <= r_oq_rd + 1'b1;
        end
        r_out_cnt <= r_out_cnt + CW'(w_rsp_keep) - CW'(w_pop);
      end
    end
  end

  // NOTE: the queue storage is reset on purpose so if_instr/if_pc read zero
  // out of reset; it is tiny, so the extra reset fan-out is negligible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pq_mem[i]   <= '0;
        r_oq_pc[i]    <= '0;
        r_oq_instr[i] <= '0;
      end
    end else if (!redirect_valid) begin
      if (w_accept) begin
        r_pq_mem[r_pq_wr] <= r_pc;
      end
      if (w_rsp_keep) begin
        r_oq_pc[r_oq_wr]    <= r_pq_mem[r_pq_rd];
        r_oq_instr[r_oq_wr] <= imem_rsp_data;
      end
    end
  end

  a_rsp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (r_outst != '0));
  a_out_queue_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    w_rsp_keep |-> (r_out_cnt != DEPTH_CNT));
  a_stale_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    r_stale <= r_outst);
  a_credit_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    w_inflight_sum <= DEPTH_SUM);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with epoch-tagged
// requests, output scoreboard, a startup vector table and targeted sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } oexp_t;

  typedef struct {
    logic        req_valid;
    logic [31:0] req_addr;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
  } vec_t;

  mreq_t       memq[$];
  oexp_t       expq[$];
  logic [31:0] delivered[$];
  logic [31:0] exp_pc;
  int          epoch;
  int          cyc;
  int          lat;
  int          n_acc;
  int          n_tests;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present this cycle's memory response, sample outputs, update the model.
  task automatic step_sample();
    mreq_t m;
    oexp_t e;
    bit    have_rsp;
    have_rsp = 1'b0;
    m = '{addr: 32'h0, due: 0, epoch: 0};
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      m = memq.pop_front();
      have_rsp = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(m.addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
    #1;
    check("if_valid", 32'(if_valid), 32'(expq.size() != 0));
    if (if_valid && if_ready && expq.size() > 0) begin
      e = expq.pop_front();
      check("if_pc", if_pc, e.pc);
      check("if_instr", if_instr, e.instr);
      delivered.push_back(if_pc);
    end
    if (redirect_valid) check("req_valid_on_redirect", 32'(imem_req_valid), 32'd0);
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_pc);
      memq.push_back('{addr: imem_req_addr, due: cyc + lat, epoch: epoch});
      exp_pc += 32'd4;
      n_acc++;
    end
    if (have_rsp && m.epoch == epoch && !redirect_valid)
      expq.push_back('{pc: m.addr, instr: mem_word(m.addr)});
    if (redirect_valid) begin
      expq.delete();
      epoch++;
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
  endtask

  task automatic step_end();
    @(negedge clk);
    cyc++;
  endtask

  task automatic step();
    step_sample();
    step_end();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    memq.delete();
    expq.delete();
    exp_pc = 32'h0;
    n_acc  = 0;
    epoch++;
    repeat (2) @(negedge clk);
    #1;
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic check_first_after(input string name, input int mark, input logic [31:0] exp);
    if (delivered.size() > mark) check(name, delivered[mark], exp);
    else check({name, "_missing"}, 32'(delivered.size()), 32'(mark + 1));
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[8];
    int   mark;
    n_tests = 0;
    n_fail  = 0;
    epoch   = 0;
    cyc     = 0;
    lat     = 1;

    // Single-cycle memory, decode always ready: one request per cycle from
    // cycle 0, instructions appear from cycle 2 onward, one per cycle.
    for (int k = 0; k < 8; k++) begin
      vec[k].req_valid = 1'b1;
      vec[k].req_addr  = 32'(4 * k);
      vec[k].out_valid = (k >= 2);
      vec[k].out_pc    = (k >= 2) ? 32'(4 * (k - 2)) : 32'h0;
      vec[k].out_instr = (k >= 2) ? mem_word(32'(4 * (k - 2))) : 32'h0;
    end

    // Startup / throughput table
    do_reset();
    lat = 1;
    if_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step_sample();
      check("tbl_req_valid", 32'(imem_req_valid), 32'(vec[k].req_valid));
      check("tbl_req_addr", imem_req_addr, vec[k].req_addr);
      check("tbl_if_valid", 32'(if_valid), 32'(vec[k].out_valid));
      if (vec[k].out_valid) begin
        check("tbl_if_pc", if_pc, vec[k].out_pc);
        check("tbl_if_instr", if_instr, vec[k].out_instr);
      end
      step_end();
    end

    // Decode stall: exactly DEPTH requests, then request line idle, head stable
    do_reset();
    lat = 1;
    if_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step_sample();
      if (k >= 2) begin
        check("stall_head_pc", if_pc, 32'h0);
        check("stall_head_instr", if_instr, mem_word(32'h0));
      end
      step_end();
    end
    step_sample();
    check("stall_req_count", 32'(n_acc), 32'd2);
    check("stall_req_valid_low", 32'(imem_req_valid), 32'd0);
    step_end();
    mark = delivered.size();
    if_ready = 1'b1;
    repeat (20) step();
    check_first_after("resume_pc0", mark, 32'h0);
    check_first_after("resume_pc1", mark + 1, 32'h4);
    check_first_after("resume_pc2", mark + 2, 32'h8);

    // 3-cycle memory: two requests in flight at 0x10/0x14, redirect to 0x103
    do_reset();
    lat = 3;
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    repeat (2) step();
    check("inflight_accepts", 32'(n_acc), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    mark = delivered.size();
    step_sample();
    check("redir_addr_aligned", imem_req_addr, 32'h100);
    check("redir_if_valid_low", 32'(if_valid), 32'd0);
    step_end();
    repeat (12) step();
    check_first_after("redir_first_pc", mark, 32'h100);

    // Redirect coinciding with a response and a decode pop (2-cycle memory)
    do_reset();
    lat = 2;
    if_ready = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step_sample();
    check("pop_at_redirect_valid", 32'(if_valid), 32'd1);
    check("rsp_at_redirect", 32'(imem_rsp_valid), 32'd1);
    step_end();
    redirect_valid = 1'b0;
    mark = delivered.size();
    step_sample();
    check("post_redir_if_valid", 32'(if_valid), 32'd0);
    check("post_redir_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_redir_req_addr", imem_req_addr, 32'h200);
    step_end();
    repeat (8) step();
    check_first_after("post_redir_first_pc", mark, 32'h200);

    // PC wrap and request-side backpressure
    do_reset();
    lat = 1;
    if_ready = 1'b1;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step_sample();
      check("hold_req_valid", 32'(imem_req_valid), 32'd1);
      check("hold_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      step_end();
    end
    imem_req_ready = 1'b1;
    step();
    step_sample();
    check("wrap_addr", imem_req_addr, 32'h0000_0000);
    step_end();
    mark = delivered.size();
    repeat (6) step();
    check("wrap_delivered", 32'(delivered.size() > mark), 32'd1);

    // Asynchronous reset mid-stream with requests outstanding
    do_reset();
    lat = 3;
    if_ready = 1'b1;
    repeat (5) step();
    step_sample();
    check("pre_rst_if_valid", 32'(if_valid), 32'd1);
    check("pre_rst_req_valid", 32'(imem_req_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_if_valid", 32'(if_valid), 32'd0);
    check("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    do_reset();
    lat = 3;
    if_ready = 1'b1;
    step_sample();
    check("restart_req_valid", 32'(imem_req_valid), 32'd1);
    check("restart_req_addr", imem_req_addr, 32'h0);
    step_end();
    repeat (10) step();

    // Randomised soak across latencies with redirects and backpressure
    for (int b = 1; b <= 4; b++) begin
      do_reset();
      lat = b;
      for (int k = 0; k < 300; k++) begin
        if_ready       = ($urandom_range(0, 3) != 0);
        imem_req_ready = ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 11) == 0);
        redirect_pc    = $urandom();
        step();
      end
      redirect_valid = 1'b0;
      if_ready = 1'b1;
      imem_req_ready = 1'b0;
      for (int k = 0; k < 40 && (memq.size() != 0 || expq.size() != 0); k++) step();
      check("soak_drained", 32'(memq.size() + expq.size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
